// File: rtl/time_counter.sv
// time_counter: packed-BCD time-of-day counter advanced by a prescaled
// tick strobe, with a handshaked set-time loader (IDLE/CHECK/ACK/WAIT).
// Build option: define TWELVE_HOUR_EN for a 12-hour clock (hours 12,01..11
// with o_pm); otherwise hours run 00..23, o_pm is tied low and i_load_pm is
// ignored. The port list is the same in both builds.
module time_counter #(
  parameter int unsigned P_TICKS_PER_SEC = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_load_valid,
  input  logic [7:0] i_load_hh,
  input  logic [7:0] i_load_mm,
  input  logic [7:0] i_load_ss,
  input  logic       i_load_pm,
  output logic [7:0] o_hh,
  output logic [7:0] o_mm,
  output logic [7:0] o_ss,
  output logic       o_pm,
  output logic       o_load_ack,
  output logic       o_load_err,
  output logic       o_min_pulse,
  output logic       o_hour_pulse,
  output logic       o_rollover
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ACK, S_WAIT} state_e;

  localparam logic [7:0] LP_LAST_TICK = 8'(P_TICKS_PER_SEC - 1);
`ifdef TWELVE_HOUR_EN
  localparam logic [7:0] LP_RESET_HH = 8'h12;
`else
  localparam logic [7:0] LP_RESET_HH = 8'h00;
`endif

  // Two-digit packed-BCD increment; callers handle the wrap values.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  state_e     state_q, state_d;
  logic [7:0] ld_hh_q, ld_mm_q, ld_ss_q;
  logic       ld_pm_q;
  logic       ld_err_q;
  logic       load_bad;
  logic       load_commit;

  logic [7:0] presc_q, presc_d;
  logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic       min_pulse_q, min_pulse_d;
  logic       hour_pulse_q, hour_pulse_d;
  logic       rollover_q, rollover_d;
`ifdef TWELVE_HOUR_EN
  logic       pm_q, pm_d;
`else
  logic       unused_load_pm;
  assign unused_load_pm = i_load_pm;
`endif

  // Load FSM state register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Load FSM next state; a request must drop before a new one is accepted.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise a missed branch infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_load_valid) state_d = S_CHECK;
      S_CHECK: state_d = S_ACK;
      S_ACK:   state_d = S_WAIT;
      S_WAIT:  if (!i_load_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Field validation of the captured load request.
  always_comb begin
    load_bad = 1'b0;
    if (ld_ss_q[3:0] > 4'd9 || ld_ss_q[7:4] > 4'd5) load_bad = 1'b1;
    if (ld_mm_q[3:0] > 4'd9 || ld_mm_q[7:4] > 4'd5) load_bad = 1'b1;
`ifdef TWELVE_HOUR_EN
    if (!((ld_hh_q[7:4] == 4'd0 && ld_hh_q[3:0] >= 4'd1 && ld_hh_q[3:0] <= 4'd9) ||
          (ld_hh_q[7:4] == 4'd1 && ld_hh_q[3:0] <= 4'd2)))
      load_bad = 1'b1;
`else
    if (ld_hh_q[3:0] > 4'd9 || ld_hh_q > 8'h23) load_bad = 1'b1;
`endif
  end

  // Capture the request in IDLE and latch the verdict in CHECK.
  always_ff @(posedge i_clk) begin
    // NOTE: these holding registers need no reset: IDLE always writes them
    // before CHECK or ACK reads them.
    if (state_q == S_IDLE && i_load_valid) begin
      ld_hh_q <= i_load_hh;
      ld_mm_q <= i_load_mm;
      ld_ss_q <= i_load_ss;
      ld_pm_q <= i_load_pm;
    end
    if (state_q == S_CHECK) ld_err_q <= load_bad;
  end

  assign load_commit = (state_q == S_ACK) && !ld_err_q;

  // Next time: a valid load wins over (and discards) a coincident tick.
  always_comb begin
    presc_d      = presc_q;
    hh_d         = hh_q;
    mm_d         = mm_q;
    ss_d         = ss_q;
    min_pulse_d  = 1'b0;
    hour_pulse_d = 1'b0;
    rollover_d   = 1'b0;
`ifdef TWELVE_HOUR_EN
    pm_d         = pm_q;
`endif
    if (load_commit) begin
      presc_d = 8'd0;
      hh_d    = ld_hh_q;
      mm_d    = ld_mm_q;
      ss_d    = ld_ss_q;
`ifdef TWELVE_HOUR_EN
      pm_d    = ld_pm_q;
`endif
    end else if (i_tick) begin
      if (presc_q != LP_LAST_TICK) begin
        presc_d = presc_q + 8'd1;
      end else begin
        presc_d = 8'd0;
        if (ss_q != 8'h59) begin
          ss_d = bcd_inc(ss_q);
        end else begin
          ss_d        = 8'h00;
          min_pulse_d = 1'b1;
          if (mm_q != 8'h59) begin
            mm_d = bcd_inc(mm_q);
          end else begin
            mm_d         = 8'h00;
            hour_pulse_d = 1'b1;
`ifdef TWELVE_HOUR_EN
            if (hh_q == 8'h12) begin
              hh_d = 8'h01;
            end else if (hh_q == 8'h11) begin
              hh_d       = 8'h12;
              pm_d       = !pm_q;
              rollover_d = pm_q;
            end else begin
              hh_d = bcd_inc(hh_q);
            end
`else
            if (hh_q == 8'h23) begin
              hh_d       = 8'h00;
              rollover_d = 1'b1;
            end else begin
              hh_d = bcd_inc(hh_q);
            end
`endif
          end
        end
      end
    end
  end

  // Time, prescaler and carry-strobe registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc_q      <= 8'd0;
      hh_q         <= LP_RESET_HH;
      mm_q         <= 8'h00;
      ss_q         <= 8'h00;
      min_pulse_q  <= 1'b0;
      hour_pulse_q <= 1'b0;
      rollover_q   <= 1'b0;
`ifdef TWELVE_HOUR_EN
      pm_q         <= 1'b0;
`endif
    end else begin
      presc_q      <= presc_d;
      hh_q         <= hh_d;
      mm_q         <= mm_d;
      ss_q         <= ss_d;
      min_pulse_q  <= min_pulse_d;
      hour_pulse_q <= hour_pulse_d;
      rollover_q   <= rollover_d;
`ifdef TWELVE_HOUR_EN
      pm_q         <= pm_d;
`endif
    end
  end

  assign o_hh         = hh_q;
  assign o_mm         = mm_q;
  assign o_ss         = ss_q;
`ifdef TWELVE_HOUR_EN
  assign o_pm         = pm_q;
`else
  assign o_pm         = 1'b0;
`endif
  assign o_load_ack   = (state_q == S_ACK);
  assign o_load_err   = (state_q == S_ACK) && ld_err_q;
  assign o_min_pulse  = min_pulse_q;
  assign o_hour_pulse = hour_pulse_q;
  assign o_rollover   = rollover_q;

endmodule
